// File: rtl/cute_lock_pkg.sv
// rtl/cute_lock_pkg.sv - shared Cute-Lock types and default schedule constants
package cute_lock_pkg;

  localparam int DEF_KEY_W    = 14;
  localparam int DEF_NUM_KEYS = 4;
  localparam int DEF_SEG_LEN  = 11;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ARMED = 2'd1,
    SEQ_RUN   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/cute_seg_counter.sv
// rtl/cute_seg_counter.sv - two-level segment position / key index counter
module cute_seg_counter #(
  parameter int SEG_LEN  = 11,
  parameter int NUM_KEYS = 4,
  parameter int POS_W    = 4,
  parameter int IDX_W    = 2
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [IDX_W-1:0] seg_idx_o,
  output logic             frame_wrap_o
);

  logic [POS_W-1:0] pos_q, pos_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pos_last, idx_last;

  assign pos_last = (pos_q == POS_W'(SEG_LEN - 1));
  assign idx_last = (idx_q == IDX_W'(NUM_KEYS - 1));

  always_comb begin
    pos_d = pos_q;
    idx_d = idx_q;
    if (clr_i) begin
      pos_d = '0;
      idx_d = '0;
    end else if (en_i) begin
      if (pos_last) begin
        pos_d = '0;
        idx_d = idx_last ? '0 : idx_q + 1'b1;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    pos_q <= pos_d;
    idx_q <= idx_d;
  end

  assign seg_idx_o    = idx_q;
  assign frame_wrap_o = en_i & pos_last & idx_last;

endmodule

// File: rtl/cute_key_sequencer.sv
// rtl/cute_key_sequencer.sv - key store and time-varying key schedule for a Cute-Lock FSM
module cute_key_sequencer
  import cute_lock_pkg::*;
#(
  parameter int KEY_W    = DEF_KEY_W,
  parameter int NUM_KEYS = DEF_NUM_KEYS,
  parameter int SEG_LEN  = DEF_SEG_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [$clog2(NUM_KEYS)-1:0] load_idx,
  input  logic [KEY_W-1:0]            load_key,
  input  logic                        run,
  output logic [KEY_W-1:0]            key_out,
  output logic                        key_valid,
  output logic [$clog2(NUM_KEYS)-1:0] seg_idx,
  output logic                        frame_start,
  output logic                        armed
);

  localparam int IDX_W = $clog2(NUM_KEYS);
  localparam int POS_W = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;

  seq_state_t          state_q, state_d;
  logic [KEY_W-1:0]    keys_q [NUM_KEYS];
  logic [KEY_W-1:0]    keys_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] mask_q, mask_d;
  logic                fs_q, fs_d;
  logic                load_fire;
  logic                in_run;
  logic                frame_wrap;
  logic [IDX_W-1:0]    idx;

  assign in_run     = (state_q == SEQ_RUN);
  assign load_ready = ~in_run;
  assign load_fire  = load_valid & load_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    keys_d  = keys_q;
    if (load_fire) begin
      keys_d[load_idx] = load_key;
      mask_d[load_idx] = 1'b1;
    end
    case (state_q)
      SEQ_IDLE:  if (&mask_d) state_d = SEQ_ARMED;
      // A write in the same cycle as run takes priority and delays entry by one cycle.
      SEQ_ARMED: if (run && !load_fire) state_d = SEQ_RUN;
      SEQ_RUN:   if (!run) state_d = SEQ_ARMED;
      default:   state_d = SEQ_IDLE;
    endcase
    if (clear) begin
      state_d = SEQ_IDLE;
      mask_d  = '0;
      for (int i = 0; i < NUM_KEYS; i++) keys_d[i] = '0;
    end
  end

  // Pulse marks the first cycle of every frame, including the first after entry.
  always_comb begin
    fs_d = (state_d == SEQ_RUN) && (!in_run || frame_wrap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      mask_q  <= '0;
      fs_q    <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) keys_q[i] <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      fs_q    <= fs_d;
      keys_q  <= keys_d;
    end
  end

  cute_seg_counter #(
    .SEG_LEN  (SEG_LEN),
    .NUM_KEYS (NUM_KEYS),
    .POS_W    (POS_W),
    .IDX_W    (IDX_W)
  ) u_seg_counter (
    .clk          (clk),
    .clr_i        (rst | (state_d != SEQ_RUN)),
    .en_i         (in_run),
    .seg_idx_o    (idx),
    .frame_wrap_o (frame_wrap)
  );

  assign key_out     = in_run ? keys_q[idx] : '0;
  assign key_valid   = in_run;
  assign seg_idx     = idx;
  assign frame_start = fs_q;
  assign armed       = &mask_q;

endmodule

// File: tb/tb_cute_key_sequencer.sv
// tb/tb_cute_key_sequencer.sv - scoreboard bench for cute_key_sequencer
module tb_cute_key_sequencer;

  localparam int KW = 14;
  localparam int NK = 4;
  localparam int SL = 11;
  localparam int FL = NK * SL;

  typedef struct packed {
    logic [KW-1:0] key;
    logic          kv;
    logic [1:0]    idx;
    logic          fs;
    logic          arm;
    logic          rdy;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [1:0]    load_idx = '0;
  logic [KW-1:0] load_key = '0;
  logic          run = 1'b0;
  logic [KW-1:0] key_out;
  logic          key_valid;
  logic [1:0]    seg_idx;
  logic          frame_start;
  logic          armed;

  int checks = 0;
  int failures = 0;
  int fs_seen = 0;

  exp_t q[$];

  logic [KW-1:0] m_keys [NK];
  bit            m_loaded [NK];
  bit            m_run = 0;
  int            m_t = 0;

  cute_key_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_idx    (load_idx),
    .load_key    (load_key),
    .run         (run),
    .key_out     (key_out),
    .key_valid   (key_valid),
    .seg_idx     (seg_idx),
    .frame_start (frame_start),
    .armed       (armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_full();
    bit f = 1;
    for (int i = 0; i < NK; i++) f &= m_loaded[i];
    return f;
  endfunction

  // Reference: schedule position is a plain frame count; key = count / SEG_LEN.
  task automatic model_edge();
    bit   fire;
    bit   full;
    exp_t e;
    full = m_full();
    if (rst || clear) begin
      for (int i = 0; i < NK; i++) begin m_keys[i] = '0; m_loaded[i] = 0; end
      m_run = 0;
      m_t = 0;
    end else begin
      fire = load_valid && !m_run;
      if (m_run) begin
        if (run) m_t = (m_t + 1) % FL;
        else begin m_run = 0; m_t = 0; end
      end else if (full && run && !fire) begin
        m_run = 1;
        m_t = 0;
      end
      if (fire) begin
        m_keys[load_idx] = load_key;
        m_loaded[load_idx] = 1;
      end
    end
    e.key = m_run ? m_keys[m_t / SL] : '0;
    e.kv  = m_run;
    e.idx = m_run ? 2'(m_t / SL) : 2'd0;
    e.fs  = m_run && (m_t == 0);
    e.arm = m_full();
    e.rdy = !m_run;
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #2;
    end
  endtask

  task automatic load(input int idx, input logic [KW-1:0] key);
    load_valid = 1'b1;
    load_idx   = 2'(idx);
    load_key   = key;
    cyc(1);
    load_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("key_out", int'(key_out), int'(e.key));
      chk("key_valid", int'(key_valid), int'(e.kv));
      chk("seg_idx", int'(seg_idx), int'(e.idx));
      chk("frame_start", int'(frame_start), int'(e.fs));
      chk("armed", int'(armed), int'(e.arm));
      chk("load_ready", int'(load_ready), int'(e.rdy));
      if (frame_start) fs_seen++;
    end
  end

  logic [KW-1:0] tk [NK];
  int fs0;

  initial begin
    tk[0] = 14'h129D; tk[1] = 14'h0BFE; tk[2] = 14'h31BB; tk[3] = 14'h1748;
    for (int i = 0; i < NK; i++) begin m_keys[i] = '0; m_loaded[i] = 0; end

    cyc(2);
    rst = 1'b0;
    cyc(1);

    for (int i = 0; i < NK; i++) load(i, tk[i]);
    run = 1'b1;
    @(negedge clk); #1;
    fs0 = fs_seen;
    cyc(100);
    @(negedge clk); #1;
    chk("frame_start_pulses_100", fs_seen - fs0, 3);

    run = 1'b0;
    cyc(2);
    clear = 1'b1;
    run = 1'b1;
    cyc(1);
    clear = 1'b0;
    for (int i = 0; i < 3; i++) load(i, tk[i]);
    cyc(5);
    load(3, tk[3]);
    cyc(18);

    run = 1'b0;
    cyc(3);
    run = 1'b1;
    cyc(15);

    load_valid = 1'b1; load_idx = 2'd1; load_key = 14'h3FFF;
    cyc(20);
    load_valid = 1'b0;
    cyc(5);

    cyc(30 - 5 - ((15 + 20) % FL) + FL);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(3);
    for (int i = 0; i < NK; i++) load(i, tk[i]);
    cyc(50);

    run = 1'b0;
    cyc(2);
    load_valid = 1'b1; load_idx = 2'd2; load_key = 14'h2A55;
    run = 1'b1;
    cyc(1);
    load_valid = 1'b0;
    cyc(40);

    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      clear      = ($urandom_range(0, 149) == 0);
      load_valid = ($urandom_range(0, 5) == 0);
      load_idx   = 2'($urandom_range(0, NK - 1));
      load_key   = KW'($urandom);
      if ($urandom_range(0, 29) == 0) run = ~run;
      cyc(1);
    end
    rst = 1'b0; clear = 1'b0; load_valid = 1'b0; run = 1'b0;
    cyc(2);

    @(negedge clk); #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cute_key_sequencer.md
# cute_key_sequencer

Key-schedule generator that drives the `keyinput` bus of a Cute-Lock time-varying locked FSM. It stores `NUM_KEYS` key words programmed over a valid/ready load port. While running, it presents key *i* for `SEG_LEN` consecutive cycles, advances to key *i+1*, and wraps after `NUM_KEYS*SEG_LEN` cycles. Its counter stays in lockstep with the locked FSM's internal segment counter. The block sits on the activation side of the lock, between the key store or tamper logic and the locked benchmark.

## Interface
Parameters:
- `KEY_W`, 14, width of one key word
- `NUM_KEYS`, 4, number of keys in the schedule
- `SEG_LEN`, 11, cycles each key is held; frame length `NUM_KEYS*SEG_LEN` (44)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `clear`  in  1  synchronous zeroize of all key words and the loaded mask
- `load_valid`  in  1  key write request
- `load_ready`  out  1  write accepted when `load_valid & load_ready`
- `load_idx`  in  $clog2(NUM_KEYS)  slot to write
- `load_key`  in  KEY_W  key value; bit `KEY_W-1` maps to `keyinput0`
- `run`  in  1  level request to stream keys
- `key_out`  out  KEY_W  current key; `key_out[KEY_W-1-i]` drives `keyinput<i>`
- `key_valid`  out  1  high in RUN
- `seg_idx`  out  $clog2(NUM_KEYS)  active key slot
- `frame_start`  out  1  one-cycle pulse while frame count is 0 in RUN
- `armed`  out  1  all slots loaded

## Operation
- Storage: `NUM_KEYS` × `KEY_W` registers, plus a `NUM_KEYS`-bit loaded mask.
- States:
  - IDLE: mask not full.
  - ARMED: mask full, not running.
  - RUN: streaming keys.
- Transitions:
  - IDLE→ARMED when the mask becomes full.
  - ARMED→RUN when `run=1` and there is no accepted load this cycle.
  - RUN→ARMED when `run=0`.
  - Any state→IDLE on `clear`.
- `load_ready` = 1 in IDLE and ARMED, 0 in RUN. An accepted write sets the slot's mask bit. Rewriting a loaded slot is allowed.
- In RUN, position counter `seg_pos` (0..SEG_LEN-1) and `seg_idx` (0..NUM_KEYS-1) advance every cycle:
  - `seg_pos` wraps to 0 after `SEG_LEN-1`, and `seg_idx` then increments.
  - `seg_idx` wraps to 0 after `NUM_KEYS-1`.
  - No divider is used. Frame count = `seg_idx*SEG_LEN + seg_pos`.
- `key_out` = key[`seg_idx`] when in RUN, else all zeros. It is combinational from registered state, with no added latency.
- Leaving RUN clears `seg_pos` and `seg_idx` to 0. Re-entry always starts at key 0, count 0.

## Timing
- Reset values:
  - state IDLE; all keys 0; mask 0; `seg_pos` 0, `seg_idx` 0.
  - `key_out` 0, `key_valid` 0, `frame_start` 0, `armed` 0, `load_ready` 1.
- A load accepted at edge *n* shows in `armed` after edge *n* if it completes the mask.
- First RUN cycle (the cycle after the ARMED→RUN edge): `seg_idx`=0, `frame_start`=1, `key_out`=key0.
- Key *i* holds for exactly `SEG_LEN` cycles. Frame counts 0–10 give key0, 11–21 key1, 22–32 key2, 33–43 key3, then count 0 again.
- Simultaneous `load_valid` and `run` in ARMED: the load wins and RUN entry slips one cycle.
- `clear` with `run`: `clear` wins and the state goes to IDLE.
- `rst` or `clear` mid-RUN: outputs are zero on the next cycle and keys are lost.
- `load_valid` in RUN is ignored; no storage change.
- `run` in IDLE is ignored.

## Structure
- Shared package `cute_lock_pkg`:
  - state enum `seq_state_t` (IDLE, ARMED, RUN)
  - default `KEY_W` / `NUM_KEYS` / `SEG_LEN` constants, shared with the locked benchmarks
- One sub-module, `cute_seg_counter`: a two-level `seg_pos`/`seg_idx` counter with synchronous clear, enable, and wrap outputs.

## Test plan
- Load 0x129D, 0x0BFE, 0x31BB, 0x1748 into slots 0–3, then `run`=1 for 100 cycles → `key_out` = 0x129D for counts 0–10, 0x0BFE for 11–21, 0x31BB for 22–32, 0x1748 for 33–43, then repeat. `frame_start` pulses at cycles 0, 44, 88.
- Load slots 0–2 only, then `run`=1 → stays IDLE, `key_valid`=0, `key_out`=0. Loading slot 3 sets `armed`=1 and RUN follows on the next edge.
- `run` dropped at count 17 and raised again → `key_out`=0 while ARMED; restart at key0 with `frame_start`=1.
- `load_valid` (slot 1, 0x3FFF) in RUN → `load_ready`=0 and slot 1 still streams 0x0BFE.
- Assert `rst` at count 30, then reload all keys and run → all outputs zero after reset and the mask is cleared; after reload the schedule restarts at count 0.
- In ARMED, assert `load_valid` and `run` together → the write to slot 2 lands, RUN starts one cycle later, and the new slot-2 value appears at count 22.
